sr_latch_driver: RTL and testbench

Synchronous controller that drives the S/R inputs of a cross-coupled NOR SR latch from a single-level request interface. It converts each accepted level request into a timed, mutually exclusive S or R pulse. It then confirms the result from the latch's Q/Qc feedback and reports done or error. It sits between clocked control logic and any asynchronous latch cell, and is the only block permitted to drive that latch.

---
 rtl/sr_latch_driver.sv | 118 +++++++++++
 tb/tb_sr_latch_driver.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: turns a single-level request into a timed, mutually
// exclusive S or R pulse for a cross-coupled NOR latch, then confirms the
// latch state from its Q/Qc feedback and reports done or err.
module sr_latch_driver #(
    parameter int PULSE_W = 2,
    parameter int TIMEOUT = 8,
    parameter int GAP     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_level,
    output logic req_ready,
    output logic S,
    output logic R,
    input  logic q_fb,
    input  logic qc_fb,
    output logic done,
    output logic err,
    output logic level
);

    // One shared counter sized for the longest of the three timed phases.
    localparam int CNT_MAX_PW = (PULSE_W > TIMEOUT) ? PULSE_W : TIMEOUT;
    localparam int CNT_MAX    = (CNT_MAX_PW > GAP) ? CNT_MAX_PW : GAP;
    localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             fb_match;

    // A valid match needs complementary feedback; Q==Qc (both 0 during a
    // NOR race, or a fault) is never accepted as confirmation.
    assign fb_match = (q_fb == level) && (qc_fb == !level);

    // Request/pulse/confirm/gap sequencer; every output is a register so the
    // latch cell never sees combinational glitches on S or R.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            S         <= 1'b0;
            R         <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            level     <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            // done and err are single-cycle strobes.
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        level     <= req_level;
                        S         <= req_level;
                        R         <= !req_level;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        state     <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (cnt == PULSE_LAST) begin
                        S     <= 1'b0;
                        R     <= 1'b0;
                        cnt   <= '0;
                        state <= ST_WAIT;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_WAIT: begin
                    if (fb_match) begin
                        done  <= 1'b1;
                        cnt   <= '0;
                        state <= ST_GAP;
                    end else if (cnt == TIMEOUT_LAST) begin
                        err   <= 1'b1;
                        cnt   <= '0;
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt       <= '0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    S         <= 1'b0;
                    R         <= 1'b0;
                    cnt       <= '0;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: drives two driver instances (default timing and the
// minimum PULSE_W/TIMEOUT/GAP corner) against registered NOR-latch models
// and checks them every cycle against a timeline model plus literal points.
module tb_sr_latch_driver;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // Clock generator, period 10.
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance 0: default parameters.
    logic v0 = 1'b0, l0 = 1'b0, stuck0 = 1'b0, lq0 = 1'b0;
    logic rdy0, s0, r0, done0, err0, lvl0, qf0, qcf0;
    // Instance 1: PULSE_W=1, TIMEOUT=1, GAP=1.
    logic v1 = 1'b0, l1 = 1'b0, stuck1 = 1'b0, lq1 = 1'b0;
    logic rdy1, s1, r1, done1, err1, lvl1, qf1, qcf1;

    // Feedback either follows the latch or is stuck with Q=Qc=0.
    assign qf0  = stuck0 ? 1'b0 : lq0;
    assign qcf0 = stuck0 ? 1'b0 : ~lq0;
    assign qf1  = stuck1 ? 1'b0 : lq1;
    assign qcf1 = stuck1 ? 1'b0 : ~lq1;

    // Latch cells seen through a synchroniser: state updates on the clock edge.
    always @(posedge clk) begin
        if (s0) lq0 <= 1'b1; else if (r0) lq0 <= 1'b0;
        if (s1) lq1 <= 1'b1; else if (r1) lq1 <= 1'b0;
    end

    sr_latch_driver #(.PULSE_W(2), .TIMEOUT(8), .GAP(1)) dut0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_level(l0), .req_ready(rdy0),
        .S(s0), .R(r0), .q_fb(qf0), .qc_fb(qcf0),
        .done(done0), .err(err0), .level(lvl0)
    );

    sr_latch_driver #(.PULSE_W(1), .TIMEOUT(1), .GAP(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_level(l1), .req_ready(rdy1),
        .S(s1), .R(r1), .q_fb(qf1), .qc_fb(qcf1),
        .done(done1), .err(err1), .level(lvl1)
    );

    // Timeline model: a request accepted at edge t0 drives S/R for edges
    // [t0, t0+pw), samples feedback at edges t0+pw+1 .. t0+pw+to, and frees
    // the interface gap edges after the result edge.
    typedef struct {
        logic busy;
        logic ready;
        logic lvl;
        logic resolved;
        logic s;
        logic r;
        logic done;
        logic err;
        logic level;
        int   t0;
        int   t_res;
    } mdl_t;

    function automatic mdl_t mreset();
        mdl_t n;
        n.busy = 1'b0; n.ready = 1'b1; n.lvl = 1'b0; n.resolved = 1'b0;
        n.s = 1'b0; n.r = 1'b0; n.done = 1'b0; n.err = 1'b0; n.level = 1'b0;
        n.t0 = 0; n.t_res = 0;
        return n;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input int e, input int pw,
                                   input int to, input int gap, input logic v,
                                   input logic rl, input logic qf, input logic qcf);
        mdl_t n;
        n = m;
        n.done = 1'b0;
        n.err  = 1'b0;
        if (m.ready && v) begin
            n.busy = 1'b1; n.t0 = e; n.lvl = rl; n.level = rl; n.resolved = 1'b0;
        end else if (m.busy) begin
            if (!m.resolved && e > m.t0 + pw) begin
                if (qf == m.lvl && qcf == !m.lvl) begin
                    n.resolved = 1'b1; n.t_res = e; n.done = 1'b1;
                end else if (e == m.t0 + pw + to) begin
                    n.resolved = 1'b1; n.t_res = e; n.err = 1'b1;
                end
            end else if (m.resolved && e == m.t_res + gap) begin
                n.busy = 1'b0;
            end
        end
        n.ready = !n.busy;
        n.s = n.busy && n.lvl && (e < n.t0 + pw);
        n.r = n.busy && !n.lvl && (e < n.t0 + pw);
        return n;
    endfunction

    mdl_t m0, m1;
    int   cyc = 0;

    // Advance both models on every edge; reset clears them like the DUT.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m0 <= mreset();
            m1 <= mreset();
        end else begin
            cyc <= cyc + 1;
            m0  <= mstep(m0, cyc + 1, 2, 8, 1, v0, l0, qf0, qcf0);
            m1  <= mstep(m1, cyc + 1, 1, 1, 1, v1, l1, qf1, qcf1);
        end
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("m0_S", s0, m0.s);        chk("m0_R", r0, m0.r);
        chk("m0_done", done0, m0.done); chk("m0_err", err0, m0.err);
        chk("m0_level", lvl0, m0.level); chk("m0_ready", rdy0, m0.ready);
        chk("m0_SR_excl", s0 & r0, 1'b0); chk("m0_done_err_excl", done0 & err0, 1'b0);
        chk("m1_S", s1, m1.s);        chk("m1_R", r1, m1.r);
        chk("m1_done", done1, m1.done); chk("m1_err", err1, m1.err);
        chk("m1_level", lvl1, m1.level); chk("m1_ready", rdy1, m1.ready);
        chk("m1_SR_excl", s1 & r1, 1'b0); chk("m1_done_err_excl", done1 & err1, 1'b0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready0(input int budget);
        int n = 0;
        while (rdy0 !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("wait_ready0_budget", rdy0, 1'b1);
    endtask

    // Directed sequence with hand-computed expectations.
    initial begin
        #1 rst = 1'b1;
        tick(); tick();
        chk("rst_ready", rdy0, 1'b1); chk("rst_S", s0, 1'b0); chk("rst_R", r0, 1'b0);
        chk("rst_done", done0, 1'b0); chk("rst_err", err0, 1'b0); chk("rst_level", lvl0, 1'b0);
        rst = 1'b0;
        tick();

        // Set request from reset.
        v0 = 1'b1; l0 = 1'b1; tick();                       // E0
        v0 = 1'b0;
        chk("set_S_e0", s0, 1'b1); chk("set_R_e0", r0, 1'b0);
        chk("set_ready_e0", rdy0, 1'b0); chk("set_level", lvl0, 1'b1);
        tick(); chk("set_S_e1", s0, 1'b1);                  // E1
        tick(); chk("set_S_e2", s0, 1'b0); chk("set_done_e2", done0, 1'b0);
        tick(); chk("set_done_e3", done0, 1'b1); chk("set_ready_e3", rdy0, 1'b0);
        tick(); chk("set_done_e4", done0, 1'b0); chk("set_ready_e4", rdy0, 1'b1);

        // Reset request.
        v0 = 1'b1; l0 = 1'b0; tick();                       // E0
        v0 = 1'b0;
        chk("rreq_R_e0", r0, 1'b1); chk("rreq_S_e0", s0, 1'b0);
        tick(); chk("rreq_R_e1", r0, 1'b1);
        tick(); chk("rreq_R_e2", r0, 1'b0);
        tick(); chk("rreq_done_e3", done0, 1'b1); chk("rreq_level", lvl0, 1'b0);
        chk("rreq_q", qf0, 1'b0); chk("rreq_qc", qcf0, 1'b1);
        tick(); chk("rreq_ready_e4", rdy0, 1'b1);

        // Busy ignore: valid held, level toggling.
        for (int i = 0; i < 10; i++) begin
            v0 = 1'b1; l0 = ~l0; tick();
        end
        v0 = 1'b0;
        wait_ready0(20);

        // Timeout with stuck feedback.
        stuck0 = 1'b1;
        v0 = 1'b1; l0 = 1'b1; tick();                       // E0
        v0 = 1'b0;
        chk("to_S_e0", s0, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("to_done", done0, 1'b0);
            chk("to_err", err0, (k == 10));
            chk("to_ready", rdy0, 1'b0);
        end
        tick(); chk("to_ready_e11", rdy0, 1'b1); chk("to_err_e11", err0, 1'b0);
        stuck0 = 1'b0;

        // Asynchronous reset one cycle into the pulse.
        v0 = 1'b1; l0 = 1'b1; tick();                       // E0
        v0 = 1'b0;
        tick(); chk("arst_S_e1", s0, 1'b1);                 // E1
        rst = 1'b1;
        #1;
        chk("arst_S_async", s0, 1'b0); chk("arst_R_async", r0, 1'b0);
        chk("arst_ready_async", rdy0, 1'b1);
        tick(); tick();
        rst = 1'b0;
        chk("arst_done", done0, 1'b0); chk("arst_err", err0, 1'b0);
        chk("arst_level", lvl0, 1'b0); chk("arst_ready", rdy0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("arst_no_done", done0, 1'b0);
            chk("arst_no_err", err0, 1'b0);
        end

        // Corner instance, latch connected.
        v1 = 1'b1; l1 = 1'b1; tick();                       // E0
        v1 = 1'b0;
        chk("c_S_e0", s1, 1'b1);
        tick(); chk("c_S_e1", s1, 1'b0); chk("c_done_e1", done1, 1'b0);
        tick(); chk("c_done_e2", done1, 1'b1); chk("c_err_e2", err1, 1'b0);
        tick(); chk("c_ready_e3", rdy1, 1'b1);

        // Corner instance, feedback stuck.
        stuck1 = 1'b1;
        v1 = 1'b1; l1 = 1'b0; tick();                       // E0
        v1 = 1'b0;
        chk("cs_R_e0", r1, 1'b1);
        tick(); chk("cs_R_e1", r1, 1'b0);
        tick(); chk("cs_err_e2", err1, 1'b1); chk("cs_done_e2", done1, 1'b0);
        tick(); chk("cs_ready_e3", rdy1, 1'b1);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
